// File: rtl/toy_hazard_ctrl.sv
// toy_hazard_ctrl: pipeline hazard and redirect control for the 5-stage
// RISC_TOY core. Tracks pending load writes per register, stalls ID on a
// load-use dependency, and sequences the IF/ID squash after a taken
// branch/jump resolves in EX.
// Optional feature: define HAZ_PERF_EN to add the saturating PERF_STALL and
// PERF_FLUSH event counters.
module toy_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int LD_LAT    = 1,
  parameter int FLUSH_CYC = 2
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          ID_VALID,
  input  logic [AW-1:0] ID_RA0,
  input  logic          ID_RA0_USE,
  input  logic [AW-1:0] ID_RA1,
  input  logic          ID_RA1_USE,
  input  logic [AW-1:0] ID_WREG,
  input  logic          ID_WEN,
  input  logic          ID_IS_LD,
  input  logic          EX_BR_TAKEN,
  input  logic [31:0]   EX_BR_TARGET,
  output logic          STALL_IF,
  output logic          STALL_ID,
  output logic          BUBBLE_EX,
  output logic          FLUSH,
  output logic          PC_SEL,
  output logic [31:0]   PC_TARGET,
  output logic          BUSY
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0]   PERF_STALL,
  output logic [15:0]   PERF_FLUSH
`endif
);

  // A load latency of 0 or 1 still needs a 1-bit counter.
  localparam int            CW         = (LD_LAT > 1) ? $clog2(LD_LAT + 1) : 1;
  localparam logic [CW-1:0] LD_INIT    = CW'(LD_LAT);
  localparam logic [1:0]    FLUSH_INIT = 2'(FLUSH_CYC - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t        state;
  logic [1:0]    flush_cnt;
  logic [31:0]   pc_target_q;
  logic [CW-1:0] cnt [NREG];

  logic run;
  logic redirect;
  logic haz;
  logic stall;
  logic sb_load;
  logic any_pending;

  // Hazard detection and issue qualification; a redirect always beats a stall.
  assign run      = (state == ST_RUN);
  assign redirect = run & EX_BR_TAKEN;
  assign haz      = ID_VALID & run &
                    ((ID_RA0_USE & (cnt[ID_RA0] != '0)) |
                     (ID_RA1_USE & (cnt[ID_RA1] != '0)));
  assign stall    = haz & ~redirect;
  assign sb_load  = ID_VALID & ~stall & run & ~EX_BR_TAKEN & ID_WEN & ID_IS_LD;

  // Reduce the scoreboard to a single pending flag for BUSY.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves the variable
    // unassigned, which would otherwise infer a latch.
    any_pending = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      any_pending = any_pending | (cnt[i] != '0);
    end
  end

  // Per-register pending-load counters: load on LD issue, otherwise count down.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      // NOTE: these counters are control state, not bulk storage, so every
      // entry is reset; a stale nonzero count would stall forever.
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        // NOTE: non-blocking assignment so every entry sees pre-edge values.
        if (sb_load && (ID_WREG == AW'(i))) begin
          cnt[i] <= LD_INIT;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  // Redirect FSM: capture the target and hold FLUSH for the squash window.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_RUN;
      flush_cnt   <= 2'd0;
      pc_target_q <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (EX_BR_TAKEN) begin
            pc_target_q <= EX_BR_TARGET;
            if (FLUSH_CYC > 1) begin
              flush_cnt <= FLUSH_INIT;
              state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          flush_cnt <= flush_cnt - 2'd1;
          if (flush_cnt <= 2'd1) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign STALL_IF  = stall;
  assign STALL_ID  = stall;
  assign BUBBLE_EX = haz | redirect | ~run;
  assign FLUSH     = redirect | ~run;
  assign PC_SEL    = redirect;
  assign PC_TARGET = redirect ? EX_BR_TARGET : pc_target_q;
  assign BUSY      = any_pending | ~run;

`ifdef HAZ_PERF_EN
  // Saturating event counters for hazard cycles and accepted redirects.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PERF_STALL <= 16'd0;
      PERF_FLUSH <= 16'd0;
    end else begin
      if (haz && (PERF_STALL != 16'hFFFF)) begin
        PERF_STALL <= PERF_STALL + 16'd1;
      end
      if (redirect && (PERF_FLUSH != 16'hFFFF)) begin
        PERF_FLUSH <= PERF_FLUSH + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/toy_hazard_ctrl.md
Name: toy_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RISC_TOY core (IF, ID, EX, MEM, WB).
- Holds a per-register scoreboard of pending writes, detects load-use hazards at ID, and produces the stall and bubble controls.
- Sequences the redirect/flush when a branch or jump resolves taken in EX.
- Sits beside the pipeline registers; the core's IF/ID/EX enables, PC mux and squash logic are driven only from this block.

Parameters:
- NREG, 32, number of architectural registers tracked by the scoreboard.
- AW, 5, register address width.
- LD_LAT, 1, stall cycles a dependent instruction waits behind a load (LD/LDR); 0 disables load stalls.
- FLUSH_CYC, 2, number of younger pipeline slots (IF, ID) squashed on a taken redirect; 1..3.

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- ID_VALID  in  1  valid instruction present in ID.
- ID_RA0  in  AW  first source register of ID instruction.
- ID_RA0_USE  in  1  ID_RA0 is actually read.
- ID_RA1  in  AW  second source register.
- ID_RA1_USE  in  1  ID_RA1 is actually read.
- ID_WREG  in  AW  destination register of ID instruction.
- ID_WEN  in  1  ID instruction writes ID_WREG.
- ID_IS_LD  in  1  ID instruction is LD/LDR.
- EX_BR_TAKEN  in  1  branch/jump in EX resolved taken.
- EX_BR_TARGET  in  32  redirect byte address.
- STALL_IF  out  1  hold PC and IF/ID register.
- STALL_ID  out  1  hold ID stage.
- BUBBLE_EX  out  1  load a NOP into ID/EX.
- FLUSH  out  1  squash IF and ID contents.
- PC_SEL  out  1  1 = next PC is PC_TARGET.
- PC_TARGET  out  32  redirect address.
- BUSY  out  1  any scoreboard entry nonzero or flush in progress.

Behaviour:
- Reset (RSTN low, asynchronous): all scoreboard counters 0; FSM in RUN; flush counter 0. All outputs 0, PC_TARGET = 0.
- Scoreboard: one counter per register, width clog2(LD_LAT+1), minimum 1 bit.
  - Every cycle, each nonzero counter decrements by 1.
  - Issue = ID_VALID & ~STALL_ID & state RUN & ~EX_BR_TAKEN.
  - On issue with ID_WEN & ID_IS_LD, counter[ID_WREG] loads LD_LAT. The load wins over the decrement for that entry in the same cycle.
  - ALU writes are not tracked; the core forwards them.
- Hazard (combinational):
  - haz = ID_VALID & state RUN & ((ID_RA0_USE & cnt[ID_RA0]!=0) | (ID_RA1_USE & cnt[ID_RA1]!=0)).
  - When haz: STALL_IF = STALL_ID = BUBBLE_EX = 1, and no scoreboard load occurs.
- With LD_LAT = 1, a dependent instruction directly behind a load stalls exactly 1 cycle. An independent instruction does not stall.
- FSM with two states, RUN and FLUSH:
  - RUN, EX_BR_TAKEN = 1:
    - Same cycle (combinational): PC_SEL = 1, PC_TARGET = EX_BR_TARGET, FLUSH = 1, BUBBLE_EX = 1.
    - STALL_IF and STALL_ID are forced to 0; redirect beats hazard.
    - If FLUSH_CYC > 1: flush counter = FLUSH_CYC-1 and go to FLUSH; otherwise stay in RUN.
  - FLUSH:
    - FLUSH = 1 and BUBBLE_EX = 1; stalls 0; PC_SEL = 0.
    - ID_VALID and EX_BR_TAKEN are ignored, because those slots are squashed.
    - Counter decrements each cycle; return to RUN when it reaches 0.
  - PC_TARGET holds the last redirect value and is otherwise stable.
- Scoreboard counters keep decrementing during FLUSH, since older loads still complete.
- Same register as both sources: a single check, with the same stall result.
- BUSY = (any cnt != 0) | (state == FLUSH).
- Reset asserted mid-flush or mid-stall: immediate return to the reset state; no pending stalls survive.

Optional Feature:
- Macro HAZ_PERF_EN.
- When defined, the block adds outputs PERF_STALL[15:0] and PERF_FLUSH[15:0]. Both are saturating counters, reset to 0.
  - PERF_STALL increments on each cycle with haz = 1.
  - PERF_FLUSH increments on each cycle with EX_BR_TAKEN accepted in RUN.
  - Both hold at 16'hFFFF once saturated.
- When undefined, these ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset: hold RSTN = 0 for 3 cycles, then release. All outputs are 0 and BUSY = 0.
- Load-use:
  - Issue LD with WREG = 5, then next cycle ID uses RA0 = 5 with RA0_USE = 1.
  - Required: STALL_IF, STALL_ID and BUBBLE_EX high for exactly 1 cycle, then the dependent instruction issues with no stall.
- Independent: LD to r5 followed by an instruction reading r6 and r7 -> no stall. Also: RA0 = 5 with RA0_USE = 0 -> no stall.
- Taken branch: EX_BR_TAKEN = 1 with target 0x0000_0040 (FLUSH_CYC = 2).
  - PC_SEL = 1 and PC_TARGET = 0x40 in that cycle.
  - FLUSH high for 2 cycles.
  - An ID_VALID LD in either flush cycle creates no scoreboard entry.
- Collision: a load-use hazard and EX_BR_TAKEN in the same cycle -> stalls 0, FLUSH = 1, PC_SEL = 1.
- Perf (HAZ_PERF_EN): 3 load-use stalls plus 2 redirects -> PERF_STALL = 3, PERF_FLUSH = 2. After forcing 70000 stall cycles, PERF_STALL = 16'hFFFF.
